// File: rtl/mux5_rr_arbiter_if.sv
// Requester/consumer bus of the 5-way round-robin burst arbiter.
// master = requester and consumer side, slave = arbiter.
interface mux5_rr_arbiter_if;
  logic [4:0] req_valid;
  logic [4:0] req_last;
  logic [4:0] req_ready;
  logic [2:0] sel;
  logic [4:0] grant;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       timeout_err;

  modport master (
    output req_valid, req_last, out_ready,
    input  req_ready, sel, grant, out_valid, out_last, timeout_err
  );

  modport slave (
    input  req_valid, req_last, out_ready,
    output req_ready, sel, grant, out_valid, out_last, timeout_err
  );
endinterface

// File: rtl/mux5_rr_arbiter.sv
// Round-robin burst arbiter driving the select of a shared 5:1 mux.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module mux5_rr_arbiter #(
  parameter int NREQ    = 5,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mux5_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state;
  logic [4:0] grant_q;
  logic [2:0] sel_q;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic [2:0] ptr_next;
  logic       last_xfer;

  if (NREQ != 5 || TIMEOUT < 2) begin : g_cfg_check
    $error("mux5_rr_arbiter: NREQ must be 5 and TIMEOUT >= 2");
  end

  // First requester at or after ptr, wrapping modulo 5.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 3'((32'(ptr) + k) % 32'd5);
      if (!found && bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // grant is zero outside BURST, so masking with it covers the state check.
  assign bus.req_ready = grant_q & {5{bus.out_ready}};
  assign bus.out_valid = |(bus.req_valid & grant_q);
  assign bus.out_last  = |(bus.req_last & grant_q) & bus.out_valid;
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;

  assign last_xfer = |(bus.req_valid & bus.req_last & grant_q) & bus.out_ready;
  assign ptr_next  = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  logic          timeout_q;
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state   <= BURST;
            grant_q <= 5'(1) << win;
            sel_q   <= win;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        BURST: begin
          // A last beat in the expiry cycle wins over the forced release.
          if (last_xfer) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= ptr_next;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            grant_q   <= '0;
            ptr       <= ptr_next;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Self-checking bench for mux5_rr_arbiter: directed scenarios plus random
// traffic, all compared against a request-queue level reference model.
module tb_mux5_rr_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mux5_rr_arbiter_if bus();

  mux5_rr_arbiter #(.NREQ(5), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: owner is the requester holding the bus, -1 when idle.
  int   owner = -1;
  int   m_ptr = 0;
  int   m_sel = 0;
  int   bcnt  = 0;
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [4:0] v, input logic [4:0] l,
                            input logic rdy);
    if (r) begin
      owner = -1; m_ptr = 0; m_sel = 0; bcnt = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < 5; k++) begin
          if (owner < 0 && v[(m_ptr + k) % 5]) owner = (m_ptr + k) % 5;
        end
        if (owner >= 0) begin
          m_sel = owner;
          bcnt  = 0;
        end
      end else begin
        bcnt++;
        if (v[owner] && l[owner] && rdy) begin
          m_ptr = (owner + 1) % 5;
          owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (bcnt == TO) begin
          m_ptr = (owner + 1) % 5;
          owner = -1;
          m_err = 1'b1;
        end
`endif
      end
    end
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic [4:0] v, input logic [4:0] l,
                       input logic rdy);
    logic [4:0] eg;
    logic       ev;
    rst = r; bus.req_valid = v; bus.req_last = l; bus.out_ready = rdy;
    #2;
    eg = (owner < 0) ? 5'd0 : 5'(1 << owner);
    ev = (owner >= 0) && v[owner];
    chk("grant",       32'(bus.grant),       32'(eg));
    chk("sel",         32'(bus.sel),         32'(m_sel));
    chk("out_valid",   32'(bus.out_valid),   32'(ev));
    chk("out_last",    32'(bus.out_last),    32'(ev && l[owner]));
    chk("req_ready",   32'(bus.req_ready),   32'(rdy ? eg : 5'd0));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    @(posedge clk);
    model_edge(r, v, l, rdy);
    #1;
  endtask

  initial begin
    int beats;
    int q_sel[$];
    int held;
    int errs;
    logic rdy;

    bus.req_valid = '1; bus.req_last = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    model_edge(1'b1, '1, '0, 1'b0);
    #1;

    // Reset with every requester asking
    cycle(1'b1, 5'b11111, 5'b00000, 1'b0);
    cycle(1'b1, 5'b11111, 5'b00000, 1'b0);
    chk("rst_grant", 32'(bus.grant), 32'd0);

    // Two requesters, single-beat bursts alternate 2,4,2
    for (int i = 0; i < 7; i++) cycle(1'b0, 5'b10100, 5'b11111, 1'b1);

    // 4-beat burst from requester 1 with a stalling consumer while 3 waits
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    cycle(1'b0, 5'b01010, 5'b00000, 1'b1);
    chk("burst_grant1", 32'(bus.grant), 32'h02);
    beats = 0; rdy = 1'b1;
    for (int i = 0; i < 20 && beats < 4; i++) begin
      cycle(1'b0, 5'b01010, (beats == 3) ? 5'b00010 : 5'b00000, rdy);
      if (rdy) beats++;
      rdy = ~rdy;
    end
    chk("burst_beats", 32'(beats), 32'd4);
    chk("burst_idle", 32'(bus.grant), 32'd0);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    chk("burst_next3", 32'(bus.grant), 32'h08);

    // All five requesting continuously
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
      if (bus.grant != 5'd0) q_sel.push_back(int'(bus.sel));
    end
    chk("rr_count", 32'(q_sel.size()), 32'd6);
    for (int i = 0; i < 6 && i < q_sel.size(); i++)
      chk("rr_order", 32'(q_sel[i]), 32'(i % 5));

    // Reset in the middle of a burst, with ptr moved away from 0 beforehand
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    cycle(1'b0, 5'b00010, 5'b00010, 1'b1);
    cycle(1'b0, 5'b00010, 5'b00010, 1'b1);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    chk("mid_grant3", 32'(bus.grant), 32'h08);
    cycle(1'b1, 5'b01000, 5'b00000, 1'b1);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    cycle(1'b0, 5'b11111, 5'b00000, 1'b1);
    chk("mid_rst_restart", 32'(bus.grant), 32'h01);

`ifdef ARB_TIMEOUT_EN
    // Requester 0 never finishes its burst
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    held = 0; errs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 5'b00011, 5'b00000, 1'b1);
      if (bus.grant == 5'b00001) held++;
      if (bus.timeout_err) errs++;
    end
    chk("to_held", 32'(held), 32'(TO));
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_next", 32'(bus.grant), 32'h02);
`else
    held = 0; errs = 0;
`endif

    // Random traffic
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            5'($urandom),
            5'($urandom) & 5'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
